// File: rtl/ioctl_dl_router.sv
// rtl/ioctl_dl_router.sv - routes the hps_io ioctl byte stream to per-channel word targets
// Packs bytes into words with byte enables, tracks load status/size and holds the CPU around downloads.
module ioctl_dl_router #(
    parameter int CHANNELS    = 4,
    parameter int INDEX_BASE  = 0,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dn_download,
    input  logic                  dn_wr,
    input  logic [24:0]           dn_addr,
    input  logic [7:0]            dn_data,
    input  logic [7:0]            dn_index,
    output logic [CHANNELS-1:0]   wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_be,
    output logic [CHANNELS-1:0]   loaded,
    output logic [24:0]           last_size,
    output logic                  overflow,
    output logic                  cpu_hold
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LB     = $clog2(BYTES);
    localparam int LANE_W = (LB > 0) ? LB : 1;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int HC_W   = $clog2(HOLD_CYCLES + 2);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0]   pk_addr_q, pk_addr_d;
    logic [DATA_W-1:0]   pk_data_q, pk_data_d;
    logic [BYTES-1:0]    pk_be_q, pk_be_d;
    logic                pk_full_q, pk_full_d;
    logic [24:0]         size_q, size_d;
    logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CHANNELS-1:0] loaded_q, loaded_d;
    logic [24:0]         last_size_q, last_size_d;
    logic                overflow_q, overflow_d;

    logic [24:0]         addr_hi;
    logic [ADDR_W-1:0]   waddr;
    logic [LANE_W-1:0]   lane;
    logic                lane_top;
    logic [25:0]         addr_p1;
    logic [9:0]          idx_off;
    logic                in_range;
    logic                start;
    logic                emit;
    logic                accept;

    assign addr_hi  = dn_addr >> (LB + ADDR_W);
    assign waddr    = ADDR_W'(dn_addr >> LB);
    assign lane     = LANE_W'(dn_addr & 25'(BYTES - 1));
    assign lane_top = (lane == LANE_W'(BYTES - 1));
    assign addr_p1  = {1'b0, dn_addr} + 26'd1;
    // Signed-style offset: bit 9 set means the index is below INDEX_BASE.
    assign idx_off  = {2'b00, dn_index} - 10'(INDEX_BASE);
    assign in_range = !idx_off[9] && (idx_off < 10'(CHANNELS));

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        pk_addr_d   = pk_addr_q;
        pk_data_d   = pk_data_q;
        pk_be_d     = pk_be_q;
        pk_full_d   = pk_full_q;
        size_d      = size_q;
        hold_cnt_d  = hold_cnt_q;
        loaded_d    = loaded_q;
        last_size_d = last_size_q;
        overflow_d  = overflow_q;
        emit        = 1'b0;
        accept      = 1'b0;
        start       = 1'b0;

        case (state_q)
            S_IDLE: begin
                start = dn_download && in_range;
            end
            S_RECV: begin
                // A completed word waits one cycle in the packer before it leaves.
                if (pk_full_q) begin
                    emit = 1'b1;
                end
                if (dn_wr) begin
                    if (addr_hi != 25'd0) begin
                        overflow_d = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if ((pk_be_q != '0) && (waddr != pk_addr_q)) begin
                            emit = 1'b1;
                        end
                    end
                end
                if (emit) begin
                    pk_data_d = '0;
                    pk_be_d   = '0;
                    pk_full_d = 1'b0;
                end
                if (accept) begin
                    pk_addr_d                = waddr;
                    pk_data_d[lane*8 +: 8]   = dn_data;
                    pk_be_d[lane]            = 1'b1;
                    if (lane_top) begin
                        pk_full_d = 1'b1;
                    end
                    if (addr_p1 > {1'b0, size_q}) begin
                        size_d = addr_p1[24:0];
                    end
                end
                if (!dn_download) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                emit             = (pk_be_q != '0);
                pk_data_d        = '0;
                pk_be_d          = '0;
                pk_full_d        = 1'b0;
                loaded_d[ch_q]   = 1'b1;
                last_size_d      = size_q;
                hold_cnt_d       = '0;
                state_d          = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                start = dn_download && in_range;
                if (!start) begin
                    if (hold_cnt_q == HC_W'(HOLD_CYCLES - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d    = S_RECV;
            ch_d       = CH_W'(idx_off);
            pk_data_d  = '0;
            pk_be_d    = '0;
            pk_full_d  = 1'b0;
            overflow_d = 1'b0;
            size_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            pk_addr_q   <= '0;
            pk_data_q   <= '0;
            pk_be_q     <= '0;
            pk_full_q   <= 1'b0;
            size_q      <= '0;
            hold_cnt_q  <= '0;
            loaded_q    <= '0;
            last_size_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pk_addr_q   <= pk_addr_d;
            pk_data_q   <= pk_data_d;
            pk_be_q     <= pk_be_d;
            pk_full_q   <= pk_full_d;
            size_q      <= size_d;
            hold_cnt_q  <= hold_cnt_d;
            loaded_q    <= loaded_d;
            last_size_q <= last_size_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_en     = emit ? (CHANNELS'(1) << ch_q) : '0;
    assign wr_addr   = pk_addr_q;
    assign wr_data   = pk_data_q;
    assign wr_be     = pk_be_q;
    assign loaded    = loaded_q;
    assign last_size = last_size_q;
    assign overflow  = overflow_q;
    assign cpu_hold  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ioctl_dl_router.sv
// tb/tb_ioctl_dl_router.sv - scoreboard bench for ioctl_dl_router
// Expected word writes are queued with the stimulus and popped by a write monitor.
module tb_ioctl_dl_router;

    logic        clk;
    logic        reset_n;
    logic        dn_download;
    logic        dn_wr;
    logic [24:0] dn_addr;
    logic [7:0]  dn_data;
    logic [7:0]  dn_index;
    logic [3:0]  wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [3:0]  loaded;
    logic [24:0] last_size;
    logic        overflow;
    logic        cpu_hold;

    typedef struct packed {
        logic [3:0]  en;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  hold_drops = 0;
    logic watch_hold = 1'b0;

    ioctl_dl_router dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dn_download (dn_download),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .dn_index    (dn_index),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .loaded      (loaded),
        .last_size   (last_size),
        .overflow    (overflow),
        .cpu_hold    (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got en=%b addr=%h data=%h be=%b, required no write",
                         wr_en, wr_addr, wr_data, wr_be);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({wr_en, wr_addr, wr_data, wr_be} !== e) begin
                    errors++;
                    $display("FAIL write_word: got en=%b addr=%h data=%h be=%b, required en=%b addr=%h data=%h be=%b",
                             wr_en, wr_addr, wr_data, wr_be, e.en, e.addr, e.data, e.be);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (watch_hold && cpu_hold !== 1'b1) hold_drops++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        step();
        dn_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        dn_index    = idx;
        dn_download = 1'b1;
        step();
    endtask

    task automatic end_dl();
        dn_download = 1'b0;
        step();
    endtask

    task automatic count_hold(output int n);
        n = 0;
        while (cpu_hold === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (wr_en !== 4'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0000", wr_en); end
        checks++;
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold: got %b required 0", cpu_hold); end
        checks++;
        if (loaded !== 4'b0) begin errors++; $display("FAIL reset_loaded: got %b required 0000", loaded); end
        checks++;
        if (last_size !== 25'd0) begin errors++; $display("FAIL reset_last_size: got %0d required 0", last_size); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    endtask

    task automatic test_basic();
        int n;
        start_dl(8'd1);
        checks++;
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_start: got %b required 1", cpu_hold); end
        exp_q.push_back('{4'b0010, 16'd0, 16'h2211, 2'b11});
        exp_q.push_back('{4'b0010, 16'd1, 16'h4433, 2'b11});
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        checks++;
        if (wr_en !== 4'b0010 || wr_data !== 16'h2211) begin
            errors++;
            $display("FAIL basic_latency: got en=%b data=%h required en=0010 data=2211", wr_en, wr_data);
        end
        send_byte(25'd2, 8'h33);
        send_byte(25'd3, 8'h44);
        step();
        end_dl();
        count_hold(n);
        checks++;
        if (n != 17) begin errors++; $display("FAIL basic_hold_len: got %0d required 17", n); end
        checks++;
        if (loaded !== 4'b0010) begin errors++; $display("FAIL basic_loaded: got %b required 0010", loaded); end
        checks++;
        if (last_size !== 25'd4) begin errors++; $display("FAIL basic_last_size: got %0d required 4", last_size); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_odd_length();
        int n;
        start_dl(8'd2);
        exp_q.push_back('{4'b0100, 16'd0, 16'hBBAA, 2'b11});
        exp_q.push_back('{4'b0100, 16'd1, 16'h00CC, 2'b01});
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        send_byte(25'd2, 8'hCC);
        end_dl();
        count_hold(n);
        checks++;
        if (last_size !== 25'd3) begin errors++; $display("FAIL odd_last_size: got %0d required 3", last_size); end
        checks++;
        if (loaded !== 4'b0110) begin errors++; $display("FAIL odd_loaded: got %b required 0110", loaded); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL odd_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_non_contiguous();
        int n;
        start_dl(8'd3);
        exp_q.push_back('{4'b1000, 16'd0, 16'h005A, 2'b01});
        exp_q.push_back('{4'b1000, 16'd3, 16'h00A5, 2'b01});
        send_byte(25'd0, 8'h5A);
        step();
        dn_wr   = 1'b1;
        dn_addr = 25'd6;
        dn_data = 8'hA5;
        #1;
        checks++;
        if (wr_en !== 4'b1000 || wr_addr !== 16'd0 || wr_be !== 2'b01) begin
            errors++;
            $display("FAIL noncontig_emit_on_strobe: got en=%b addr=%h be=%b required en=1000 addr=0000 be=01",
                     wr_en, wr_addr, wr_be);
        end
        step();
        dn_wr = 1'b0;
        end_dl();
        count_hold(n);
        checks++;
        if (last_size !== 25'd7) begin errors++; $display("FAIL noncontig_last_size: got %0d required 7", last_size); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL noncontig_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_out_of_range();
        start_dl(8'd9);
        checks++;
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL oor_hold_start: got %b required 0", cpu_hold); end
        send_byte(25'd0, 8'h01);
        send_byte(25'd1, 8'h02);
        checks++;
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL oor_hold_bytes: got %b required 0", cpu_hold); end
        end_dl();
        step();
        checks++;
        if (loaded !== 4'b1110) begin errors++; $display("FAIL oor_loaded: got %b required 1110", loaded); end
        checks++;
        if (last_size !== 25'd7) begin errors++; $display("FAIL oor_last_size: got %0d required 7", last_size); end
    endtask

    task automatic test_overflow();
        start_dl(8'd0);
        send_byte(25'h20000, 8'hEE);
        step();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
        exp_q.push_back('{4'b0001, 16'd0, 16'h7700, 2'b10});
        send_byte(25'd1, 8'h77);
        end_dl();
        step();
        checks++;
        if (last_size !== 25'd2) begin errors++; $display("FAIL ovf_last_size: got %0d required 2", last_size); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
        checks++;
        if (loaded !== 4'b1111) begin errors++; $display("FAIL ovf_loaded: got %b required 1111", loaded); end
    endtask

    task automatic test_back_to_back();
        int n;
        watch_hold = 1'b1;
        repeat (4) step();
        start_dl(8'd0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear: got %b required 0", overflow); end
        exp_q.push_back('{4'b0001, 16'd0, 16'h2010, 2'b11});
        exp_q.push_back('{4'b0001, 16'd1, 16'h4030, 2'b11});
        send_byte(25'd0, 8'h10);
        send_byte(25'd1, 8'h20);
        send_byte(25'd2, 8'h30);
        dn_download = 1'b0;
        send_byte(25'd3, 8'h40);
        watch_hold = 1'b0;
        checks++;
        if (hold_drops != 0) begin errors++; $display("FAIL b2b_hold_continuous: got %0d drops required 0", hold_drops); end
        count_hold(n);
        checks++;
        if (n != 17) begin errors++; $display("FAIL b2b_hold_len: got %0d required 17", n); end
        checks++;
        if (last_size !== 25'd4) begin errors++; $display("FAIL b2b_last_size: got %0d required 4", last_size); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_recv();
        start_dl(8'd1);
        send_byte(25'd0, 8'h99);
        reset_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 4'b0) begin errors++; $display("FAIL rst_mid_wr_en: got %b required 0000", wr_en); end
        checks++;
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_mid_cpu_hold: got %b required 0", cpu_hold); end
        checks++;
        if (loaded !== 4'b0 || overflow !== 1'b0 || last_size !== 25'd0) begin
            errors++;
            $display("FAIL rst_mid_status: got loaded=%b ovf=%b size=%0d required 0000 0 0", loaded, overflow, last_size);
        end
        dn_download = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got %b required 0", cpu_hold); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rst_mid_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    initial begin
        reset_n     = 1'b0;
        dn_download = 1'b0;
        dn_wr       = 1'b0;
        dn_addr     = '0;
        dn_data     = '0;
        dn_index    = '0;
        repeat (3) step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_basic();
        test_odd_length();
        test_non_contiguous();
        test_out_of_range();
        test_overflow();
        test_back_to_back();
        test_reset_mid_recv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
